// File: rtl/if_pipe_ctrl.sv
// if_pipe_ctrl
//   Sequencing controller for the instruction-fetch stage and the IF/ID
//   register. It arbitrates between start-up, instruction-memory wait,
//   load-use hazards and control-flow redirects (branch, j, jr). It produces
//   the PC hold, IF/ID hold, kill and reset controls and an ID/EX bubble
//   request.
//
//   Parameters
//     STARTUP_CYCLES  edges IFrst stays low after pcRst rises (1..15)
//     IMEM_TIMEOUT    consecutive not-ready cycles before imem_err (1..255)
//
//   Ports
//     clk, pcRst         clock (rising edge); asynchronous active-low reset
//     imem_ready         instruction word for the current PC is valid
//     brflag/jflag/jrflag redirects resolved in ID
//     ex_is_load, ex_rt  load currently in ID/EX and its destination
//     id_rs, id_rt,      source fields of the instruction in IF/ID
//     id_uses_rt
//     pcHold, IFhold     hold the PC / IF/ID register
//     IFkill, IDkill     load a bubble into IF/ID / ID/EX at the next edge
//     IFrst              active-low reset to the IF/ID register
//     imem_err           sticky imem wait timeout flag
//
//   Optional build macro IF_PIPE_STATS_EN adds stall_cnt and flush_cnt
//   (32-bit, wrapping) counting held-PC cycles and redirect squashes.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   START  | after reset; IF/ID held in reset for STARTUP_CYCLES edges
//   RUN    | normal fetch; hazard stall and redirect squash handled here
//   IWAIT  | instruction memory not ready; PC held, bubbles flow into ID

module if_pipe_ctrl #(
  parameter int unsigned STARTUP_CYCLES = 2,
  parameter int unsigned IMEM_TIMEOUT   = 8
) (
  input  logic        clk,
  input  logic        pcRst,
  input  logic        imem_ready,
  input  logic        brflag,
  input  logic        jflag,
  input  logic        jrflag,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  output logic        pcHold,
  output logic        IFhold,
  output logic        IFkill,
  output logic        IFrst,
  output logic        IDkill,
`ifdef IF_PIPE_STATS_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        imem_err
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_IWAIT = 2'd2
  } state_t;

  localparam logic [7:0] C_START_LAST = 8'(STARTUP_CYCLES - 1);
  localparam logic [7:0] C_TIMEOUT    = 8'(IMEM_TIMEOUT);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic       r_pend, w_pend_nxt;
  logic       r_err, w_err_nxt;
  logic       w_hz, w_redir_in, w_redir_fire;

  assign w_hz = ex_is_load & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign w_redir_in = brflag | jflag | jrflag;
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign imem_err   = r_err;

  always_ff @(posedge clk or negedge pcRst) begin
    if (!pcRst) begin
      r_state <= ST_START;
      r_cnt   <= 8'd0;
      r_pend  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_pend;
    w_err_nxt    = r_err;
    w_redir_fire = 1'b0;
    pcHold       = 1'b0;
    IFhold       = 1'b0;
    IFkill       = 1'b0;
    IFrst        = 1'b1;
    IDkill       = 1'b0;

    case (r_state)
      ST_START: begin
        IFrst  = 1'b0;
        pcHold = 1'b1;
        IFhold = 1'b1;
        if (r_cnt == C_START_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      ST_RUN: begin
        if (!imem_ready) begin
          pcHold      = 1'b1;
          IFkill      = 1'b1;
          w_state_nxt = ST_IWAIT;
          w_cnt_nxt   = 8'd1;
          if (C_TIMEOUT <= 8'd1) w_err_nxt = 1'b1;
          // A redirect seen while fetch stalls is remembered; hazard-stale
          // flags are not.
          if (w_redir_in && !w_hz) w_pend_nxt = 1'b1;
        end else if (w_hz) begin
          pcHold = 1'b1;
          IFhold = 1'b1;
          IDkill = 1'b1;
        end else if (w_redir_in || r_pend) begin
          IFkill       = 1'b1;
          w_redir_fire = 1'b1;
        end
      end

      ST_IWAIT: begin
        if (imem_ready) begin
          // Exit cycle behaves as RUN on live inputs; a pending redirect is
          // taken in the first RUN-state cycle.
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 8'd0;
          if (w_hz) begin
            pcHold = 1'b1;
            IFhold = 1'b1;
            IDkill = 1'b1;
          end else if (w_redir_in) begin
            IFkill       = 1'b1;
            w_redir_fire = 1'b1;
          end
        end else begin
          pcHold    = 1'b1;
          IFkill    = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= C_TIMEOUT) w_err_nxt = 1'b1;
          if (w_redir_in && !w_hz) w_pend_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_START;
        w_cnt_nxt   = 8'd0;
      end
    endcase

    if (w_redir_fire) w_pend_nxt = 1'b0;
  end

`ifdef IF_PIPE_STATS_EN
  logic w_stall;
  assign w_stall = pcHold & ((r_state == ST_RUN) | (r_state == ST_IWAIT));

  always_ff @(posedge clk or negedge pcRst) begin
    if (!pcRst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (w_stall)      stall_cnt <= stall_cnt + 32'd1;
      if (w_redir_fire) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_pipe_ctrl.sv
module tb_if_pipe_ctrl;

  logic        clk = 1'b0;
  logic        pcRst;
  logic        imem_ready, brflag, jflag, jrflag, ex_is_load, id_uses_rt;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        pcHold, IFhold, IFkill, IFrst, IDkill, imem_err;
`ifdef IF_PIPE_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_pipe_ctrl #(.STARTUP_CYCLES(2), .IMEM_TIMEOUT(8)) dut (
    .clk        (clk),
    .pcRst      (pcRst),
    .imem_ready (imem_ready),
    .brflag     (brflag),
    .jflag      (jflag),
    .jrflag     (jrflag),
    .ex_is_load (ex_is_load),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .pcHold     (pcHold),
    .IFhold     (IFhold),
    .IFkill     (IFkill),
    .IFrst      (IFrst),
    .IDkill     (IDkill),
`ifdef IF_PIPE_STATS_EN
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
`endif
    .imem_err   (imem_err)
  );

  logic [4:0] w_ctrl;
  assign w_ctrl = {pcHold, IFhold, IFkill, IFrst, IDkill};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctrl bits: {pcHold, IFhold, IFkill, IFrst, IDkill}
  task automatic look(input string tag, input logic [4:0] exp_ctrl, input logic exp_err);
    #2;
    chk({tag, "_ctrl"}, 32'(w_ctrl), 32'(exp_ctrl));
    chk({tag, "_err"}, 32'(imem_err), 32'(exp_err));
  endtask

  initial begin
    pcRst = 1'b0; imem_ready = 1'b1; brflag = 1'b0; jflag = 1'b0; jrflag = 1'b0;
    ex_is_load = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;

    repeat (3) @(posedge clk);
    #1; look("rst", 5'b11000, 1'b0);

    tick(); pcRst = 1'b1;
    look("start0", 5'b11000, 1'b0);
    tick(); look("start1", 5'b11000, 1'b0);
    tick(); look("run0",   5'b00010, 1'b0);

    tick(); ex_is_load = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    look("hz_rs", 5'b11011, 1'b0);
    tick(); ex_is_load = 1'b0;
    look("hz_rs_done", 5'b00010, 1'b0);

    tick(); ex_is_load = 1'b1; ex_rt = 5'd7; id_rs = 5'd0; id_rt = 5'd7; id_uses_rt = 1'b1;
    look("hz_rt", 5'b11011, 1'b0);
    tick(); id_uses_rt = 1'b0;
    look("rt_unused", 5'b00010, 1'b0);
    tick(); ex_rt = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    look("r0_load", 5'b00010, 1'b0);

    tick(); ex_is_load = 1'b0; id_uses_rt = 1'b0; brflag = 1'b1;
    look("br", 5'b00110, 1'b0);
    tick(); brflag = 1'b0;
    look("br_done", 5'b00010, 1'b0);

    tick(); ex_is_load = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; jflag = 1'b1;
    look("hz_j", 5'b11011, 1'b0);
    tick(); ex_is_load = 1'b0;
    look("j_retry", 5'b00110, 1'b0);
    tick(); jflag = 1'b0;
    look("j_done", 5'b00010, 1'b0);

    tick(); imem_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      look($sformatf("wait%0d", k), 5'b10110, (k >= 9));
      tick();
    end
    imem_ready = 1'b1;
    look("wexit", 5'b00010, 1'b1);
    tick(); look("wrun", 5'b00010, 1'b1);

    tick(); imem_ready = 1'b0;
    look("p_w1", 5'b10110, 1'b1);
    tick(); jrflag = 1'b1;
    look("p_jr", 5'b10110, 1'b1);
    tick(); jrflag = 1'b0;
    look("p_w3", 5'b10110, 1'b1);
    tick(); imem_ready = 1'b1;
    look("p_exit", 5'b00010, 1'b1);
    tick(); look("p_redir", 5'b00110, 1'b1);
    tick(); look("p_done",  5'b00010, 1'b1);
`ifdef IF_PIPE_STATS_EN
    chk("stall_cnt", stall_cnt, 32'd16);
    chk("flush_cnt", flush_cnt, 32'd3);
`endif

    tick(); pcRst = 1'b0;
    look("arst", 5'b11000, 1'b0);
`ifdef IF_PIPE_STATS_EN
    chk("stall_rst", stall_cnt, 32'd0);
    chk("flush_rst", flush_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
